// File: rtl/div_unit.sv
// div_unit: sequential radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} so write-back can take HI = result[63:32]
// and LO = result[31:0] directly.
//
// Ports:
//   clk          rising-edge clock
//   resetn       synchronous active-low reset
//   div_start_i  request, sampled only in IDLE
//   div_sign     1 = signed (DIV), 0 = unsigned (DIVU); latched at accept
//   div_op1      dividend, latched at accept
//   div_op2      divisor, latched at accept
//   div_cancel_i flush; aborts any operation, result left untouched
//   result       registered {remainder, quotient}
//   div_ready_o  one-cycle pulse, result valid
//   div_busy_o   registered, high whenever the FSM is not IDLE
//
// Optional build macro DIV_EARLY_OUT_EN: when |op1| < |op2| (nonzero op2)
// the answer is known at accept and the unit goes straight to END.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 div_start_i,
  input  logic                 div_sign,
  input  logic [WIDTH-1:0]     div_op1,
  input  logic [WIDTH-1:0]     div_op2,
  input  logic                 div_cancel_i,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_ready_o,
  output logic                 div_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] result_d;
  logic               ready_d;
  logic               busy_d;

  // Two's-complement negation; |min_int| maps onto itself.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Operand magnitudes and result signs at accept.
  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] abs1, abs2;

  assign op1_neg = div_sign & div_op1[WIDTH-1];
  assign op2_neg = div_sign & div_op2[WIDTH-1];
  assign abs1    = op1_neg ? negate(div_op1) : div_op1;
  assign abs2    = op2_neg ? negate(div_op2) : div_op2;

  // One restoring step: shift {rem, quo} left, trial-subtract divisor
  // from the top WIDTH+1 bits, keep the difference if non-negative.
  logic [WIDTH:0]   shift_hi;
  logic [WIDTH:0]   trial;
  logic             step_ok;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fix_rem, fix_quo;

  assign shift_hi = {rem_q, quo_q[WIDTH-1]};
  assign trial    = shift_hi - {1'b0, dvsr_q};
  assign step_ok  = ~trial[WIDTH];
  assign step_rem = step_ok ? trial[WIDTH-1:0] : shift_hi[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], step_ok};

  // Sign fix-up applied to the final step so result lands with ready.
  assign fix_quo  = q_neg_q ? negate(step_quo) : step_quo;
  assign fix_rem  = r_neg_q ? negate(step_rem) : step_rem;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      op1_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      result      <= '0;
      div_ready_o <= 1'b0;
      div_busy_o  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      op1_q       <= op1_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      result      <= result_d;
      div_ready_o <= ready_d;
      div_busy_o  <= busy_d;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    op1_d    = op1_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result;
    ready_d  = 1'b0;

    if (div_cancel_i) begin
      // Flush wins over everything, including a same-cycle start.
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_start_i) begin
            op1_d   = div_op1;
            dvsr_d  = abs2;
            quo_d   = abs1;
            rem_d   = '0;
            cnt_d   = '0;
            q_neg_d = op1_neg ^ op2_neg;
            r_neg_d = op1_neg;
            if (div_op2 == '0) begin
              state_d = S_ZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs1 < abs2) begin
              // Quotient is zero and the dividend is the remainder.
              state_d  = S_END;
              result_d = {div_op1, {WIDTH{1'b0}}};
              ready_d  = 1'b1;
`endif
            end else begin
              state_d = S_ON;
            end
          end
        end
        S_ZERO: begin
          state_d  = S_END;
          result_d = {op1_q, {WIDTH{1'b1}}};
          ready_d  = 1'b1;
        end
        S_ON: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_d  = S_END;
            result_d = {fix_rem, fix_quo};
            ready_d  = 1'b1;
          end
        end
        S_END: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Expected {rem, quo} and the
// cycle in which ready must appear are queued at accept and compared when
// the DUT pulses ready.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic           clk;
  logic           resetn;
  logic           div_start_i;
  logic           div_sign;
  logic [W-1:0]   div_op1;
  logic [W-1:0]   div_op2;
  logic           div_cancel_i;
  logic [2*W-1:0] result;
  logic           div_ready_o;
  logic           div_busy_o;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_start_i  (div_start_i),
    .div_sign     (div_sign),
    .div_op1      (div_op1),
    .div_op2      (div_op2),
    .div_cancel_i (div_cancel_i),
    .result       (result),
    .div_ready_o  (div_ready_o),
    .div_busy_o   (div_busy_o)
  );

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_t = 0;
  logic [63:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: magnitude divide then sign fix-up; zero divisor special.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    logic        an, bn;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    an = s & a[31];
    bn = s & b[31];
    ua = an ? -a : a;
    ub = bn ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (an ^ bn) q = -q;
    if (an) r = -r;
    return {r, q};
  endfunction

  function automatic int latency(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    begin
      logic [31:0] ua, ub;
      ua = (s & a[31]) ? -a : a;
      ub = (s & b[31]) ? -b : b;
      if (ua < ub) return 1;
    end
`endif
    return 33;
  endfunction

  // Monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (div_ready_o) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 64'(div_ready_o), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", 64'(cyc), 64'(e.due));
        last_res = e.res;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  // Pulse start for one cycle; optionally queue the expected outcome.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
    int lat;
    exp_t e;
    drain();
    lat = latency(s, a, b);
    @(posedge clk); #1;
    div_sign    = s;
    div_op1     = a;
    div_op2     = b;
    div_start_i = 1'b1;
    last_t      = cyc;
    if (push) begin
      e.res = exp;
      e.due = last_t + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    div_start_i = 1'b0;
    div_sign    = $urandom_range(0, 1) == 1;
    div_op1     = $urandom;
    div_op2     = $urandom;
    if (lat > 1) begin
      @(negedge clk);
      check("hold_at_accept", result, last_res);
      check("busy_after_accept", 64'(div_busy_o), 64'(1));
    end
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  initial begin
    resetn       = 1'b0;
    div_start_i  = 1'b0;
    div_sign     = 1'b0;
    div_op1      = '0;
    div_op2      = '0;
    div_cancel_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(div_ready_o), 64'(0));
    check("reset_busy", 64'(div_busy_o), 64'(0));
    @(posedge clk); #1;
    resetn = 1'b1;

    // 100 / 7 unsigned with busy/ready timing.
    do_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    wait_cyc(last_t + 32);
    check("ready_not_early", 64'(div_ready_o), 64'(0));
    wait_cyc(last_t + 33);
    check("busy_at_end", 64'(div_busy_o), 64'(1));
    wait_cyc(last_t + 34);
    check("busy_after_end", 64'(div_busy_o), 64'(0));

    do_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b1);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 1'b1);
    do_op(1'b0, 32'h0000_1234, 32'h0000_0000, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b1);
    do_op(1'b1, 32'h8000_0005, 32'h0000_0000, {32'h8000_0005, 32'hFFFF_FFFF}, 1'b1);
    do_op(1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, 1'b1);
    do_op(1'b1, 32'hFFFF_FFFD, 32'd10, {32'hFFFF_FFFD, 32'd0}, 1'b1);
    do_op(1'b1, 32'd1000, 32'hFFFF_FFF9, {32'd6, 32'hFFFF_FF72}, 1'b1);
    drain();

    // Cancel at t+10: no ready for this op, result unchanged.
    do_op(1'b0, 32'd5000, 32'd3, 64'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 div_cancel_i = 1'b1;
    @(posedge clk); #1;
    div_cancel_i = 1'b0;
    @(negedge clk);
    check("cancel_busy", 64'(div_busy_o), 64'(0));
    check("cancel_result", result, last_res);
    repeat (40) @(negedge clk);
    check("cancel_result_late", result, last_res);
    do_op(1'b1, 32'hFFFF_F000, 32'd7, model(1'b1, 32'hFFFF_F000, 32'd7), 1'b1);

    // Random operations, with an occasional zero divisor.
    for (int i = 0; i < 8; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = $urandom_range(0, 1) == 1;
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      do_op(s, a, b, model(s, a, b), 1'b1);
    end
    drain();

    // Reset mid-operation with start held high: reset dominates.
    do_op(1'b0, 32'd77, 32'd5, model(1'b0, 32'd77, 32'd5), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    resetn      = 1'b0;
    div_start_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_result", result, 64'd0);
    check("midreset_busy", 64'(div_busy_o), 64'(0));
    check("midreset_ready", 64'(div_ready_o), 64'(0));
    @(posedge clk); #1;
    resetn      = 1'b1;
    div_start_i = 1'b0;
    last_res    = '0;
    do_op(1'b0, 32'hDEAD_BEEF, 32'd16, {32'h0000_000F, 32'h0DEA_DBEE}, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Sequential radix-2 restoring divider for the execute stage. It is the inverse companion of the multi-cycle multiplier and serves DIV/DIVU. It produces a 64-bit {remainder, quotient} result that the HI/LO write-back uses directly: HI = result[63:32], LO = result[31:0]. It is driven by a start/ready handshake from the pipeline stall controller and supports cancellation on exception flush.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.
CNT_W, 6, width of the iteration counter; must hold the value WIDTH.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  reset, synchronous, active-low
div_start_i  input  1  request; sampled only in IDLE
div_sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); latched at accept
div_op1  input  WIDTH  dividend; latched at accept
div_op2  input  WIDTH  divisor; latched at accept
div_cancel_i  input  1  flush; aborts any operation in progress
result  output  2*WIDTH  {remainder, quotient}; registered
div_ready_o  output  1  one-cycle pulse; result valid
div_busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE, counter=0, result=0, div_ready_o=0, div_busy_o=0. Reset dominates every other input.
- States and transitions:
  - IDLE -> ZERO if div_start_i=1 and div_op2=0.
  - IDLE -> ON if div_start_i=1 and div_op2 is nonzero.
  - ZERO -> END.
  - ON: counter increments each cycle; ON -> END after WIDTH cycles (counter 0..WIDTH-1).
  - END -> IDLE.
- Accept (cycle t, IDLE with start=1):
  - Latch sign, |op1|, |op2|, quotient sign = sign & (op1[MSB] ^ op2[MSB]), remainder sign = sign & op1[MSB].
  - Absolute values are computed as unsigned two's-complement negation, so |0x80000000| = 0x80000000.
- ON iteration, each cycle:
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
- END:
  - Apply sign fix-up (negate the quotient and/or remainder as latched) and write result.
  - Assert div_ready_o=1 for exactly this one cycle.
- Latency: normal operation reaches END, with ready high, in cycle t+WIDTH+1 (t+33). Divide-by-zero reaches END in cycle t+2.
- result holds its value from END until the next END or reset. It does not clear on a new accept.
- Divide-by-zero result: quotient = all ones, remainder = raw div_op1. No exception is raised.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This falls out of the algorithm with no special case.
- div_start_i is ignored while busy. If start is still high in IDLE after END, a new division is accepted. The stall controller must drop start in the cycle it sees div_ready_o.
- Operands need to be valid only in the accept cycle. Later changes on div_op1/div_op2/div_sign have no effect.
- div_cancel_i=1 in any state:
  - Next state is IDLE; div_ready_o stays 0 and result is unchanged.
  - Cancel has priority over start in the same cycle, so no accept occurs.
- div_busy_o is a registered decode of state != IDLE.

Optional Feature:
DIV_EARLY_OUT_EN.
- Defined: at accept, if |op1| < |op2| and op2 is nonzero, go IDLE -> END directly. Result = {op1 (raw), 0}, ready at t+1.
- Not defined: every nonzero-divisor operation takes the full WIDTH iterations.
- The functional result is identical either way; only latency differs.

Test Plan:
- Unsigned 100 / 7, start pulse at cycle t -> ready only at t+33; result = {0x00000002, 0x0000000E}; busy high from t+1 to t+33.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000. The same operands unsigned -> quotient 0, remainder 0x80000000.
- Divide by zero, op1 = 0x1234 -> ready at t+2; result = {0x00001234, 0xFFFFFFFF}.
- Cancel at t+10, then change operands and restart -> no ready pulse for the first op; result keeps its prior value until the new op's END; the new op is correct at its own t'+33.
- With DIV_EARLY_OUT_EN: unsigned 3 / 10 -> ready at t+1, result = {3, 0}. Without the macro, the same stimulus -> ready at t+33 with the same result.
